digit_ascii_encoder: RTL and testbench
======================================

// Module: digit_ascii_encoder
// PURPOSE
//  Inverse of the ASCII-digit scanner: walks the 16x8 register file, converts each binary
//  digit value (0..9) back to its ASCII character ('0'..'9') and writes it in place.
//  Entries outside 0..9 are overwritten with INVALID_CHAR. Counts the valid digits.
//  Drives the RegFile16x8 ports directly. Its count output feeds the two-digit display.
// PARAMETERS
//  DEPTH         16     number of register-file entries scanned (addresses 0..DEPTH-1)
//  ADDR_W        4      register-file address width; DEPTH <= 2**ADDR_W
//  ZERO_CHAR     8'h30  ASCII code added to a valid digit value
//  INVALID_CHAR  8'h3F  code written for a non-digit entry ('?')
// PORTS
//  Clk     in   1       clock; all state changes on the rising edge
//  Rst     in   1       synchronous, active-high reset
//  go      in   1       start request, level-sampled in IDLE
//  R_Addr  out  ADDR_W  register-file read address (= index i)
//  R_en    out  1       register-file read enable
//  R_Data  in   8       register-file read data; combinational from R_Addr while R_en=1
//  W_Addr  out  ADDR_W  register-file write address (= index i)
//  W_en    out  1       register-file write enable; regfile writes on the rising edge
//  W_Data  out  8       register-file write data
//  count   out  5       number of valid digits found in the current/last pass (0..16)
//  busy    out  1       high in every state except IDLE and DONE
//  done    out  1       high in DONE; pass complete, count final
// BEHAVIOUR
//  Moore FSM. R_en, W_en, busy, done decode from state. R_Addr = W_Addr = i in all states.
//  Reset (edge with Rst=1, overrides all): state=IDLE, i=0, temp=0, count=0.
//    Outputs after reset: R_en=0, W_en=0, W_Data=0, busy=0, done=0, R_Addr=W_Addr=0.
//  IDLE : go=1 -> CLR; else stay. count keeps last pass value.
//  CLR  : i<=0, count<=0 -> READ.
//  READ : R_en=1 -> LATCH.
//  LATCH: R_en=1, temp<=R_Data -> WRITE.
//  WRITE: W_en=1. W_Data = (temp<=9) ? temp+ZERO_CHAR : INVALID_CHAR (8-bit add, no wrap).
//         If temp<=9, count<=count+1. Always -> NEXT.
//  NEXT : i==DEPTH-1 -> DONE; else i<=i+1 -> READ.
//  DONE : done=1, i=0. go=0 -> IDLE; go=1 -> stay. One pass per go assertion.
//  W_Data=0 in every state except WRITE. R_en and W_en are never high together.
//  Timing: go sampled high at edge k -> CLR in cycle k+1. Entry n READ in k+2+4n.
//    Entry n WRITE in k+4+4n. done first high in cycle k+2+4*DEPTH (k+66 for DEPTH=16).
//  Classification: temp 0x00..0x09 valid. 0x0A..0xFF invalid, including ASCII 0x30..0x39.
//  count increments at most once per entry. It cannot exceed DEPTH. Width 5 holds 16.
//  go changing mid-pass is ignored. Only IDLE and DONE sample go.
//  Rst mid-pass: next state IDLE. No further W_en pulses. Entries not yet written keep their contents.
//    A WRITE cycle coinciding with the Rst edge still writes; regfile behaviour decides.
// TESTING
//  1 RF=00..09,0A..0F; go pulse -> RF=30..39,3F x6; count=10; done at cycle k+66; 16 W_en pulses.
//  2 RF all 00 -> all 30, count=16. RF all FF -> all 3F, count=0 (width/no-overflow check).
//  3 Boundary: RF[0]=09, RF[1]=0A, RF[15]=00 -> RF[0]=39, RF[1]=3F, RF[15]=30; count counts 09 and 00.
//  4 go held high through DONE -> one pass only. Drop go, re-raise -> second pass.
//    All ASCII from pass 1 -> all 3F, count=0.
//  5 Rst asserted in entry 5 READ -> IDLE next cycle. count=0, busy=0. RF[5..15] unchanged.
//    No W_en after reset.
//  6 Every cycle: assert !(R_en&&W_en) and R_Addr==W_Addr==i. Check busy/done are never high together.

Source files
------------

// File: rtl/digit_ascii_encoder.sv
// Walks a 16x8 register file, rewriting each binary digit 0..9 as its ASCII character and
// every other value as INVALID_CHAR, while counting the valid digits seen in the pass.
module digit_ascii_encoder #(
   parameter int          DEPTH        = 16,
   parameter int          ADDR_W       = 4,
   parameter logic [7:0]  ZERO_CHAR    = 8'h30,
   parameter logic [7:0]  INVALID_CHAR = 8'h3F
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              go,
   output logic [ADDR_W-1:0] R_Addr,
   output logic              R_en,
   input  logic [7:0]        R_Data,
   output logic [ADDR_W-1:0] W_Addr,
   output logic              W_en,
   output logic [7:0]        W_Data,
   output logic [4:0]        count,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_READ,
      S_LATCH,
      S_WRITE,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] i_reg;
   logic [7:0]        temp_reg;
   logic [4:0]        count_reg;
   logic              r_en_reg;
   logic              w_en_reg;
   logic [7:0]        w_data_reg;
   logic              busy_reg;
   logic              done_reg;

   function automatic logic is_digit(input logic [7:0] v);
      return (v <= 8'd9);
   endfunction

   function automatic logic [7:0] encode(input logic [7:0] v);
      return is_digit(v) ? (v + ZERO_CHAR) : INVALID_CHAR;
   endfunction

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  state_next = go ? S_CLR : S_IDLE;
         S_CLR:   state_next = S_READ;
         S_READ:  state_next = S_LATCH;
         S_LATCH: state_next = S_WRITE;
         S_WRITE: state_next = S_NEXT;
         S_NEXT:  state_next = (i_reg == LAST_IDX) ? S_DONE : S_READ;
         S_DONE:  state_next = go ? S_DONE : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs are registered from state_next so they line up with the state they describe.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_reg  <= S_IDLE;
         i_reg      <= '0;
         temp_reg   <= '0;
         count_reg  <= '0;
         r_en_reg   <= 1'b0;
         w_en_reg   <= 1'b0;
         w_data_reg <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;

         case (state_reg)
            S_CLR: begin
               i_reg     <= '0;
               count_reg <= '0;
            end
            S_LATCH: temp_reg <= R_Data;
            S_WRITE: begin
               if (is_digit(temp_reg))
                  count_reg <= count_reg + 5'd1;
            end
            S_NEXT: i_reg <= (i_reg == LAST_IDX) ? '0 : i_reg + 1'b1;
            default: ;
         endcase

         r_en_reg   <= (state_next == S_READ) || (state_next == S_LATCH);
         w_en_reg   <= (state_next == S_WRITE);
         // Only LATCH leads into WRITE, and R_Data is valid there, so encode it directly.
         w_data_reg <= (state_next == S_WRITE) ? encode(R_Data) : 8'h00;
         busy_reg   <= (state_next != S_IDLE) && (state_next != S_DONE);
         done_reg   <= (state_next == S_DONE);
      end
   end

   assign R_Addr = i_reg;
   assign W_Addr = i_reg;
   assign R_en   = r_en_reg;
   assign W_en   = w_en_reg;
   assign W_Data = w_data_reg;
   assign count  = count_reg;
   assign busy   = busy_reg;
   assign done   = done_reg;

endmodule

// File: tb/tb_digit_ascii_encoder.sv
// Scoreboard bench for digit_ascii_encoder: a register-file model answers reads, expected
// writes are queued per pass, and a negedge monitor pops and compares each W_en cycle.
module tb_digit_ascii_encoder;

   typedef logic [7:0] vec_t[16];
   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       go;
   logic [3:0] R_Addr;
   logic       R_en;
   logic [7:0] R_Data;
   logic [3:0] W_Addr;
   logic       W_en;
   logic [7:0] W_Data;
   logic [4:0] count;
   logic       busy;
   logic       done;

   logic [7:0] rf[16];
   vec_t       ld_vec;
   logic       ld = 1'b0;
   logic       mon_en = 1'b0;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  wen_pulses = 0;

   digit_ascii_encoder dut (
      .Clk(Clk), .Rst(Rst), .go(go),
      .R_Addr(R_Addr), .R_en(R_en), .R_Data(R_Data),
      .W_Addr(W_Addr), .W_en(W_en), .W_Data(W_Data),
      .count(count), .busy(busy), .done(done)
   );

   always #5 Clk = ~Clk;

   // Register-file model: combinational read, write on rising edge, bench preload port.
   assign R_Data = R_en ? rf[R_Addr] : 8'h00;
   always @(posedge Clk) begin
      if (ld) begin
         for (int n = 0; n < 16; n++) rf[n] <= ld_vec[n];
      end else if (W_en) begin
         rf[W_Addr] <= W_Data;
      end
   end

   always @(negedge Clk) begin
      if (mon_en) begin
         checks++;
         if (R_en && W_en) begin
            errors++;
            $display("FAIL ren_wen_exclusive: R_en=%b W_en=%b required not both", R_en, W_en);
         end
         checks++;
         if (R_Addr != W_Addr) begin
            errors++;
            $display("FAIL addr_match: R_Addr=%0d W_Addr=%0d required equal", R_Addr, W_Addr);
         end
         checks++;
         if (busy && done) begin
            errors++;
            $display("FAIL busy_done_exclusive: busy=%b done=%b required not both", busy, done);
         end
         if (W_en) begin
            wen_pulses++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr=%0d data=%h required no write", W_Addr, W_Data);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               $display("write addr=%0d data=%h expected addr=%0d data=%h", W_Addr, W_Data, e.addr, e.data);
               if (W_Addr != e.addr || W_Data != e.data) begin
                  errors++;
                  $display("FAIL write_value: got addr=%0d data=%h required addr=%0d data=%h",
                           W_Addr, W_Data, e.addr, e.data);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic load_rf(input vec_t v);
      ld_vec = v;
      ld = 1'b1;
      @(posedge Clk); #1;
      ld = 1'b0;
   endtask

   task automatic check_rf(input string tag, input vec_t v);
      for (int n = 0; n < 16; n++)
         chk($sformatf("%s_rf%0d", tag, n), {24'h0, rf[n]}, {24'h0, v[n]});
   endtask

   // One full pass: go sampled at edge k, done must appear 65 edges later.
   task automatic run_pass(input string tag, input vec_t exp_v, input int exp_cnt, input bit hold_go);
      int cyc;
      wen_pulses = 0;
      for (int n = 0; n < 16; n++) exp_q.push_back('{addr: 4'(n), data: exp_v[n]});
      go = 1'b1;
      @(posedge Clk); #1;
      chk({tag, "_busy_after_go"}, {31'h0, busy}, 32'd1);
      if (!hold_go) go = 1'b0;
      cyc = 0;
      while (!done && cyc < 200) begin
         @(posedge Clk); #1;
         cyc++;
      end
      chk({tag, "_done_latency"}, cyc, 32'd65);
      chk({tag, "_count"}, {27'h0, count}, exp_cnt);
      chk({tag, "_wen_pulses"}, wen_pulses, 32'd16);
      chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
      chk({tag, "_busy_in_done"}, {31'h0, busy}, 32'd0);
      chk({tag, "_addr_in_done"}, {28'h0, R_Addr}, 32'd0);
      check_rf(tag, exp_v);
      if (hold_go) begin
         repeat (8) @(posedge Clk);
         #1;
         chk({tag, "_done_held"}, {31'h0, done}, 32'd1);
         chk({tag, "_no_second_pass"}, wen_pulses, 32'd16);
         go = 1'b0;
      end
      @(posedge Clk); #1;
      chk({tag, "_idle_done"}, {31'h0, done}, 32'd0);
      chk({tag, "_idle_busy"}, {31'h0, busy}, 32'd0);
      chk({tag, "_idle_count"}, {27'h0, count}, exp_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v, e;
      Rst = 1'b1;
      go  = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_R_en", {31'h0, R_en}, 32'd0);
      chk("rst_W_en", {31'h0, W_en}, 32'd0);
      chk("rst_W_Data", {24'h0, W_Data}, 32'd0);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_addr", {28'h0, R_Addr}, 32'd0);
      chk("rst_count", {27'h0, count}, 32'd0);
      Rst = 1'b0;
      mon_en = 1'b1;

      // Test 1: ramp 00..0F.
      v = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
      e = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
            8'h38, 8'h39, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
      load_rf(v);
      run_pass("ramp", e, 10, 1'b0);

      // Test 2: all zero -> full count of 16; all FF -> zero.
      v = '{default: 8'h00};
      e = '{default: 8'h30};
      load_rf(v);
      run_pass("zeros", e, 16, 1'b0);
      v = '{default: 8'hFF};
      e = '{default: 8'h3F};
      load_rf(v);
      run_pass("ones", e, 0, 1'b0);

      // Test 3: classification boundaries, ASCII digits are not digits.
      v = '{8'h09, 8'h0A, 8'h30, 8'h39, 8'h80, 8'hFF, 8'h10, 8'h0B,
            8'h2F, 8'h3A, 8'h7F, 8'h41, 8'h20, 8'hF9, 8'h99, 8'h00};
      e = '{8'h39, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F,
            8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h30};
      load_rf(v);
      run_pass("bound", e, 2, 1'b0);

      // Test 4: go held through DONE gives one pass; second pass sees ASCII -> all invalid.
      v = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
      e = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
            8'h38, 8'h39, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
      load_rf(v);
      run_pass("hold1", e, 10, 1'b1);
      e = '{default: 8'h3F};
      run_pass("hold2", e, 0, 1'b0);

      // Test 5: reset during entry 5 READ.
      v = '{8'h05, 8'h03, 8'h0C, 8'h07, 8'h01, 8'h11, 8'h12, 8'h13,
            8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
      e = '{8'h35, 8'h33, 8'h3F, 8'h37, 8'h31, 8'h11, 8'h12, 8'h13,
            8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
      load_rf(v);
      wen_pulses = 0;
      for (int n = 0; n < 5; n++) exp_q.push_back('{addr: 4'(n), data: e[n]});
      go = 1'b1;
      @(posedge Clk); #1;
      go = 1'b0;
      repeat (21) @(posedge Clk);
      #1;
      chk("rst5_in_read_ren", {31'h0, R_en}, 32'd1);
      chk("rst5_in_read_addr", {28'h0, R_Addr}, 32'd5);
      chk("rst5_count_before", {27'h0, count}, 32'd4);
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk("rst5_busy", {31'h0, busy}, 32'd0);
      chk("rst5_done", {31'h0, done}, 32'd0);
      chk("rst5_count", {27'h0, count}, 32'd0);
      chk("rst5_ren", {31'h0, R_en}, 32'd0);
      chk("rst5_addr", {28'h0, R_Addr}, 32'd0);
      Rst = 1'b0;
      repeat (12) @(posedge Clk);
      #1;
      chk("rst5_wen_pulses", wen_pulses, 32'd5);
      chk("rst5_queue_empty", exp_q.size(), 32'd0);
      chk("rst5_stays_idle", {31'h0, busy}, 32'd0);
      check_rf("rst5", e);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
